// File: rtl/rom_read_arbiter_if.sv
// Client/ROM-side bundle for rom_read_arbiter: two burst request ports, the ROM pins and FSM debug state.
// Handshake: reqN is a level held by the client; ackN pulses for one cycle, and addrN/lenN are sampled at the end of that cycle.
interface rom_read_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic          req0;
  logic          req1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [AW-1:0] len0;
  logic [AW-1:0] len1;
  logic          ack0;
  logic          ack1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          done0;
  logic          done1;
  logic          rom_oe;
  logic [AW-1:0] rom_add;
  logic [DW-1:0] rom_op;
  logic [1:0]    fsm_state;

  modport slave (
    input  req0, req1, addr0, addr1, len0, len1, rom_op,
    output ack0, ack1, rvalid0, rvalid1, rdata0, rdata1, done0, done1,
           rom_oe, rom_add, fsm_state
  );

  modport master (
    output req0, req1, addr0, addr1, len0, len1, rom_op,
    input  ack0, ack1, rvalid0, rvalid1, rdata0, rdata1, done0, done1,
           rom_oe, rom_add, fsm_state
  );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter and burst sequencer sharing one synchronous-read ROM between two clients.
// One word is issued per cycle; data returns the following cycle to the owning client only.
module rom_read_arbiter #(
  parameter int AW = 5,
  parameter int DW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  rom_read_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic          ptr;
  logic          owner;
  logic [AW-1:0] cnt;
  logic [AW-1:0] add_q;
  logic          oe_q;
  logic          rv0_q;
  logic          rv1_q;
  logic          dn0_q;
  logic          dn1_q;
  logic          grant_any;
  logic          grant_side;

  // When both request, the pointer picks; otherwise whichever is high wins.
  always_comb begin
    grant_any  = bus.req0 | bus.req1;
    grant_side = 1'b0;
    if (bus.req0 && bus.req1) grant_side = ptr;
    else                      grant_side = bus.req1;
  end

  // ack is decided in the IDLE cycle itself so the next grant can land right after DRAIN.
  assign bus.ack0 = (state == IDLE) && grant_any && !grant_side;
  assign bus.ack1 = (state == IDLE) && grant_any &&  grant_side;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 1'b0;
      owner <= 1'b0;
      cnt   <= '0;
      add_q <= '0;
      oe_q  <= 1'b0;
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
      dn0_q <= 1'b0;
      dn1_q <= 1'b0;
    end else begin
      rv0_q <= (state == ISSUE) && !owner;
      rv1_q <= (state == ISSUE) &&  owner;
      dn0_q <= (state == ISSUE) && !owner && (cnt == '0);
      dn1_q <= (state == ISSUE) &&  owner && (cnt == '0);
      case (state)
        IDLE: begin
          if (grant_any) begin
            owner <= grant_side;
            ptr   <= ~grant_side;
            add_q <= grant_side ? bus.addr1 : bus.addr0;
            cnt   <= grant_side ? bus.len1  : bus.len0;
            oe_q  <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (cnt == '0) begin
            oe_q  <= 1'b0;
            state <= DRAIN;
          end else begin
            add_q <= add_q + AW'(1);
            cnt   <= cnt - AW'(1);
          end
        end
        DRAIN: begin
          state <= IDLE;
        end
        default: begin
          oe_q  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rom_oe    = oe_q;
  assign bus.rom_add   = add_q;
  assign bus.rvalid0   = rv0_q;
  assign bus.rvalid1   = rv1_q;
  assign bus.done0     = dn0_q;
  assign bus.done1     = dn1_q;
  assign bus.rdata0    = rv0_q ? bus.rom_op : {DW{1'b0}};
  assign bus.rdata1    = rv1_q ? bus.rom_op : {DW{1'b0}};
  assign bus.fsm_state = state;
endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: ROM model mem[i]=i, burst vector table, arbitration/reset sequences,
// and a negedge monitor popping an expected-word queue and an expected-address queue.
module tb_rom_read_arbiter;
  localparam int AW = 5;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rom_read_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  rom_read_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [DW-1:0] rom_q = '0;
  always @(posedge clk) if (bus.rom_oe) rom_q <= DW'(bus.rom_add);
  assign bus.rom_op = rom_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  logic [DW+1:0] exp_q[$];      // {side, last, data}
  logic [AW-1:0] exp_add_q[$];
  int done_cnt[2];
  int done_cyc[2];
  logic [DW-1:0] done_data[2];
  int ack_cnt[2];
  int rv_cnt0 = 0;
  logic [DW+1:0] e;

  typedef struct {
    bit            side;
    logic [AW-1:0] addr;
    logic [AW-1:0] len;
    logic [DW-1:0] exp_last;
    int            exp_lat;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ack0) ack_cnt[0]++;
      if (bus.ack1) ack_cnt[1]++;
      if (exp_add_q.size() == 0) check("rom_oe_without_burst", bus.rom_oe, 1'b0);
      else if (bus.rom_oe) check("rom_add", bus.rom_add, exp_add_q.pop_front());
      if (bus.rvalid0 || bus.rvalid1) begin
        if (exp_q.size() == 0) begin
          check("rvalid0_unexpected", bus.rvalid0, 1'b0);
          check("rvalid1_unexpected", bus.rvalid1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("rvalid_owner", {bus.rvalid1, bus.rvalid0}, e[DW+1] ? 2'b10 : 2'b01);
          if (e[DW+1]) begin
            check("rdata1", bus.rdata1, e[DW-1:0]);
            check("done1", bus.done1, e[DW]);
            check("nonowner0_quiet", {bus.rdata0, bus.done0}, '0);
          end else begin
            check("rdata0", bus.rdata0, e[DW-1:0]);
            check("done0", bus.done0, e[DW]);
            check("nonowner1_quiet", {bus.rdata1, bus.done1}, '0);
          end
        end
      end else begin
        check("quiet_outputs", {bus.rdata1, bus.rdata0, bus.done1, bus.done0}, '0);
      end
      if (bus.rvalid0) rv_cnt0++;
      if (bus.done0) begin done_cnt[0]++; done_cyc[0] = cyc; done_data[0] = bus.rdata0; end
      if (bus.done1) begin done_cnt[1]++; done_cyc[1] = cyc; done_data[1] = bus.rdata1; end
    end
  end

  task automatic expect_burst(input bit side, input logic [AW-1:0] a, input logic [AW-1:0] l);
    logic [AW-1:0] ad;
    ad = a;
    for (int i = 0; i <= int'(l); i++) begin
      exp_add_q.push_back(ad);
      exp_q.push_back({side, (i == int'(l)), DW'(ad)});
      ad = ad + AW'(1);
    end
  endtask

  task automatic set_req(input bit side, input logic v, input logic [AW-1:0] a, input logic [AW-1:0] l);
    if (side) begin bus.req1 = v; bus.addr1 = a; bus.len1 = l; end
    else      begin bus.req0 = v; bus.addr0 = a; bus.len0 = l; end
  endtask

  task automatic wait_ack(input bit side, output int t);
    t = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (side ? bus.ack1 : bus.ack0) begin t = cyc; break; end
    end
    check(side ? "ack1_seen" : "ack0_seen", (t != -1), 1'b1);
    if (t != -1) check("ack_other_low", side ? bus.ack0 : bus.ack1, 1'b0);
  endtask

  task automatic wait_done(input bit side, input int prev, output int t);
    t = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (done_cnt[side] != prev) begin t = done_cyc[side]; break; end
    end
    check("done_seen", (t != -1), 1'b1);
  endtask

  task automatic do_burst(input bit side, input logic [AW-1:0] a, input logic [AW-1:0] l,
                          output int t_ack, output int t_done);
    int pd;
    pd = done_cnt[side];
    set_req(side, 1'b1, a, l);
    wait_ack(side, t_ack);
    if (t_ack != -1) expect_burst(side, a, l);
    @(posedge clk); #1;
    set_req(side, 1'b0, '0, '0);
    wait_done(side, pd, t_done);
  endtask

  task automatic apply_reset();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    exp_add_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ta, td, prev_done, t0, t1, dc, a0, rvs;
    logic [AW-1:0] ra, rl;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.len0 = '0; bus.len1 = '0;
    done_cnt = '{0, 0}; done_cyc = '{0, 0}; ack_cnt = '{0, 0};
    done_data[0] = '0; done_data[1] = '0;

    vecs[0] = '{1'b0, 5'h03, 5'h02, 8'h05, 4};
    vecs[1] = '{1'b1, 5'h1E, 5'h03, 8'h01, 5};
    vecs[2] = '{1'b0, 5'h00, 5'h1F, 8'h1F, 33};
    vecs[3] = '{1'b1, 5'h10, 5'h00, 8'h10, 2};
    vecs[4] = '{1'b0, 5'h1F, 5'h01, 8'h00, 3};
    vecs[5] = '{1'b1, 5'h07, 5'h05, 8'h0C, 7};

    #1;
    check("rst_fsm_state", bus.fsm_state, 2'd0);
    check("rst_rom_oe", bus.rom_oe, 1'b0);
    check("rst_rom_add", bus.rom_add, '0);
    check("rst_acks", {bus.ack1, bus.ack0}, 2'b00);
    check("rst_rvalid", {bus.rvalid1, bus.rvalid0}, 2'b00);
    check("rst_done", {bus.done1, bus.done0}, 2'b00);
    check("rst_rdata", {bus.rdata1, bus.rdata0}, '0);
    apply_reset();

    // Burst table, issued back to back: each ack should land one cycle after the previous done.
    prev_done = -1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      do_burst(vecs[i].side, vecs[i].addr, vecs[i].len, ta, td);
      check("done_latency", td - ta, vecs[i].exp_lat);
      check("done_last_word", done_data[vecs[i].side], vecs[i].exp_last);
      if (prev_done != -1) check("ack_after_drain", ta - prev_done, 1);
      prev_done = td;
    end

    for (int i = 0; i < 4; i++) begin
      ra = AW'($urandom_range(0, 31));
      rl = AW'($urandom_range(0, 12));
      @(posedge clk); #1;
      do_burst(1'($urandom_range(0, 1)), ra, rl, ta, td);
      check("rand_done_latency", td - ta, 2 + int'(rl));
    end

    // Arbitration: both high after reset -> side 0, then side 1 three cycles later.
    apply_reset();
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 5'h05, 5'h00);
    set_req(1'b1, 1'b1, 5'h09, 5'h00);
    wait_ack(1'b0, t0);
    expect_burst(1'b0, 5'h05, 5'h00);
    @(posedge clk); #1; bus.req0 = 1'b0;
    wait_ack(1'b1, t1);
    expect_burst(1'b1, 5'h09, 5'h00);
    check("arb_ack1_delay", t1 - t0, 3);
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 5'h0A, 5'h00);
    set_req(1'b1, 1'b1, 5'h0B, 5'h00);
    wait_ack(1'b0, t0);
    expect_burst(1'b0, 5'h0A, 5'h00);
    check("arb_both_again_delay", t0 - t1, 3);
    @(posedge clk); #1; bus.req0 = 1'b0;
    wait_ack(1'b1, t1);
    expect_burst(1'b1, 5'h0B, 5'h00);
    @(posedge clk); #1; bus.req1 = 1'b0;
    repeat (4) @(posedge clk); #1;
    // req1 alone, then both: the second grant goes to side 0.
    set_req(1'b1, 1'b1, 5'h0C, 5'h00);
    wait_ack(1'b1, t1);
    expect_burst(1'b1, 5'h0C, 5'h00);
    @(posedge clk); #1;
    set_req(1'b1, 1'b1, 5'h0E, 5'h00);
    set_req(1'b0, 1'b1, 5'h0D, 5'h00);
    wait_ack(1'b0, t0);
    expect_burst(1'b0, 5'h0D, 5'h00);
    check("arb_second_grant_delay", t0 - t1, 3);
    @(posedge clk); #1; bus.req0 = 1'b0;
    wait_ack(1'b1, t1);
    expect_burst(1'b1, 5'h0E, 5'h00);
    @(posedge clk); #1; bus.req1 = 1'b0;
    repeat (4) @(posedge clk); #1;

    // Late request waits for IDLE; a short req0 pulse during a burst leaves no trace.
    set_req(1'b0, 1'b1, 5'h08, 5'h04);
    wait_ack(1'b0, t0);
    expect_burst(1'b0, 5'h08, 5'h04);
    @(posedge clk); #1; bus.req0 = 1'b0;
    @(posedge clk); #1;
    set_req(1'b1, 1'b1, 5'h12, 5'h01);
    wait_ack(1'b1, t1);
    expect_burst(1'b1, 5'h12, 5'h01);
    check("held_req1_ack_cycle", t1 - t0, 3 + 4);
    @(posedge clk); #1;
    bus.req1 = 1'b0;
    a0 = ack_cnt[0];
    set_req(1'b0, 1'b1, 5'h15, 5'h03);
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    repeat (8) @(posedge clk); #1;
    check("dropped_req0_no_ack", ack_cnt[0], a0);
    check("dropped_req0_no_rom_access", exp_add_q.size(), 0);

    // Reset at the 4th word of an 11-word burst.
    set_req(1'b0, 1'b1, 5'h00, 5'h0A);
    wait_ack(1'b0, t0);
    expect_burst(1'b0, 5'h00, 5'h0A);
    @(posedge clk); #1; bus.req0 = 1'b0;
    rvs = rv_cnt0;
    t1 = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (rv_cnt0 - rvs == 4) begin t1 = cyc; break; end
    end
    check("fourth_rvalid_seen", (t1 != -1), 1'b1);
    dc = done_cnt[0];
    rst_n = 1'b0;
    #1;
    check("midrst_rvalid0", bus.rvalid0, 1'b0);
    check("midrst_rdata0", bus.rdata0, '0);
    check("midrst_done0", bus.done0, 1'b0);
    check("midrst_rom_oe", bus.rom_oe, 1'b0);
    check("midrst_rom_add", bus.rom_add, '0);
    check("midrst_fsm_state", bus.fsm_state, 2'd0);
    exp_q.delete();
    exp_add_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (15) @(posedge clk); #1;
    check("midrst_no_done0", done_cnt[0], dc);
    do_burst(1'b1, 5'h02, 5'h01, ta, td);
    check("post_rst_req1_latency", td - ta, 3);

    repeat (3) @(posedge clk); #1;
    check("word_queue_empty", exp_q.size(), 0);
    check("addr_queue_empty", exp_add_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
